// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared states, port ids and command record for the memory arbiter.
package mem_arb_pkg;
  localparam int CMD_ADDR_W = 32;
  localparam int CMD_DATA_W = 32;
  localparam int CMD_MASK_W = CMD_DATA_W / 8;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;
  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
    logic [CMD_MASK_W-1:0] bmask;
    logic                  wren;
    logic                  id;
  } cmd_t;
endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: grant decision for two requesters; MEM_ARB_FAIR_EN adds a port-0 hold counter
// that forces a port-1 grant after MAX_HOLD consecutive port-0 wins.
module mem_arb_pick #(
  parameter int MAX_HOLD = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic open,
  input  logic valid0,
  input  logic valid1,
  output logic ready0,
  output logic ready1
);
  logic starve;
`ifdef MEM_ARB_FAIR_EN
  localparam int CW = $clog2(MAX_HOLD + 1);
  logic [CW-1:0] cnt;
  assign starve = cnt == CW'(MAX_HOLD);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else if (ready1) cnt <= '0;
    else if (ready0) cnt <= valid1 ? cnt + 1'b1 : '0;
`else
  logic unused;
  assign starve = 1'b0;
  assign unused = clk ^ rst;
`endif
  assign ready1 = open & valid1 & (~valid0 | starve);
  assign ready0 = open & valid0 & ~ready1;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port valid/ready arbiter sequencing one access at a time into a
// 1-cycle-latency synchronous memory; MEM_ARB_FAIR_EN enables port-1 starvation relief.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = CMD_ADDR_W,
  parameter int DATA_W   = CMD_DATA_W,
  parameter int MAX_HOLD = 4
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_req0_valid,
  output logic                o_req0_ready,
  input  logic [ADDR_W-1:0]   i_req0_addr,
  input  logic [DATA_W-1:0]   i_req0_wdata,
  input  logic [DATA_W/8-1:0] i_req0_bmask,
  input  logic                i_req0_wren,
  input  logic                i_req1_valid,
  output logic                o_req1_ready,
  input  logic [ADDR_W-1:0]   i_req1_addr,
  input  logic [DATA_W-1:0]   i_req1_wdata,
  input  logic [DATA_W/8-1:0] i_req1_bmask,
  input  logic                i_req1_wren,
  output logic                o_rsp0_valid,
  output logic [DATA_W-1:0]   o_rsp0_rdata,
  output logic                o_rsp1_valid,
  output logic [DATA_W-1:0]   o_rsp1_rdata,
  output logic                o_mem_en,
  output logic                o_mem_wren,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W-1:0]   o_mem_wdata,
  output logic [DATA_W/8-1:0] o_mem_bmask,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_busy
);
  state_t state, state_nx;
  cmd_t   cmd, cmd_in;
  logic   open, hs, rsp;
  // Reset also closes the request side so every output reads 0 while it is held.
  assign open = ~i_reset & (state == IDLE || state == RESP);
  mem_arb_pick #(.MAX_HOLD(MAX_HOLD)) u_pick (
    .clk   (i_clk),
    .rst   (i_reset),
    .open  (open),
    .valid0(i_req0_valid),
    .valid1(i_req1_valid),
    .ready0(o_req0_ready),
    .ready1(o_req1_ready)
  );
  assign hs = o_req0_ready | o_req1_ready;
  assign cmd_in = o_req1_ready
    ? '{addr: i_req1_addr, wdata: i_req1_wdata, bmask: i_req1_bmask, wren: i_req1_wren, id: PORT_AUX}
    : '{addr: i_req0_addr, wdata: i_req0_wdata, bmask: i_req0_bmask, wren: i_req0_wren, id: PORT_CPU};
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = IDLE;
    state_nx = (state == ACCESS) ? RESP : (hs ? ACCESS : IDLE);
  end
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) cmd <= '0;
    else if (hs) cmd <= cmd_in;
  assign rsp          = state == RESP;
  assign o_busy       = state == ACCESS || state == RESP;
  assign o_mem_en     = state == ACCESS;
  assign o_mem_wren   = cmd.wren;
  assign o_mem_addr   = cmd.addr;
  assign o_mem_wdata  = cmd.wdata;
  assign o_mem_bmask  = cmd.bmask;
  assign o_rsp0_valid = rsp & (cmd.id == PORT_CPU);
  assign o_rsp1_valid = rsp & (cmd.id == PORT_AUX);
  assign o_rsp0_rdata = (o_rsp0_valid & ~cmd.wren) ? i_mem_rdata : '0;
  assign o_rsp1_rdata = (o_rsp1_valid & ~cmd.wren) ? i_mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized and directed checks of mem_arbiter against a transaction-level model.
module tb_mem_arbiter;
  localparam int MAX_HOLD = 4;
`ifdef MEM_ARB_FAIR_EN
  localparam bit FAIR = 1'b1;
`else
  localparam bit FAIR = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic v[2], we[2];
  logic [31:0] a[2], wd[2];
  logic [3:0] bm[2];
  logic r0, r1, rv0, rv1, men, mwe, busy;
  logic [31:0] rd0, rd1, maddr, mwd, mrd = '0;
  logic [3:0] mbm;
  logic [31:0] mem[64] = '{default: '0};
  mem_arbiter dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0_valid(v[0]), .o_req0_ready(r0), .i_req0_addr(a[0]), .i_req0_wdata(wd[0]),
    .i_req0_bmask(bm[0]), .i_req0_wren(we[0]),
    .i_req1_valid(v[1]), .o_req1_ready(r1), .i_req1_addr(a[1]), .i_req1_wdata(wd[1]),
    .i_req1_bmask(bm[1]), .i_req1_wren(we[1]),
    .o_rsp0_valid(rv0), .o_rsp0_rdata(rd0), .o_rsp1_valid(rv1), .o_rsp1_rdata(rd1),
    .o_mem_en(men), .o_mem_wren(mwe), .o_mem_addr(maddr), .o_mem_wdata(mwd),
    .o_mem_bmask(mbm), .i_mem_rdata(mrd), .o_busy(busy)
  );
  always @(posedge clk)
    if (men) begin
      if (mwe) begin
        for (int b = 0; b < 4; b++) if (mbm[b]) mem[maddr[7:2]][8*b +: 8] <= mwd[8*b +: 8];
      end else mrd <= mem[maddr[7:2]];
    end
  // Transaction-level model: phase 0 idle, 1 memory access, 2 response.
  int ph, c_id, cnt, m_grant, d_grant, cyc;
  logic [31:0] c_addr, c_wd, c_data;
  logic [3:0] c_bm;
  logic c_we;
  logic [31:0] ref_mem[64] = '{default: '0};
  int checks = 0, errors = 0;
  int gport[$], gcyc[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic model_reset();
    ph = 0; c_id = 0; cnt = 0; c_addr = 0; c_wd = 0; c_data = 0; c_bm = 0; c_we = 0;
    for (int p = 0; p < 2; p++) begin v[p] = 0; a[p] = 0; wd[p] = 0; bm[p] = 0; we[p] = 0; end
  endtask
  task automatic set_req(input int p, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] mask, input logic wren);
    v[p] = 1; a[p] = addr; wd[p] = data; bm[p] = mask; we[p] = wren;
  endtask
  task automatic compare();
    bit can, w1, starve, e0, e1;
    can = !rst && ph != 1;
    starve = FAIR && cnt == MAX_HOLD;
    w1 = v[1] && (!v[0] || starve);
    e1 = can && w1;
    e0 = can && v[0] && !w1;
    m_grant = e0 ? 0 : (e1 ? 1 : -1);
    d_grant = (r0 && v[0]) ? 0 : ((r1 && v[1]) ? 1 : -1);
    chk("ready0", r0, e0);
    chk("ready1", r1, e1);
    chk("mem_en", men, ph == 1);
    chk("mem_wren", mwe, c_we);
    chk("mem_addr", maddr, c_addr);
    chk("mem_wdata", mwd, c_wd);
    chk("mem_bmask", mbm, c_bm);
    chk("busy", busy, ph != 0);
    chk("rsp0_valid", rv0, ph == 2 && c_id == 0);
    chk("rsp1_valid", rv1, ph == 2 && c_id == 1);
    chk("rsp0_rdata", rd0, (ph == 2 && c_id == 0 && !c_we) ? c_data : 32'h0);
    chk("rsp1_rdata", rd1, (ph == 2 && c_id == 1 && !c_we) ? c_data : 32'h0);
  endtask
  task automatic step();
    int idx;
    if (ph == 1) begin
      idx = int'(c_addr[7:2]);
      if (c_we) begin
        for (int b = 0; b < 4; b++) if (c_bm[b]) ref_mem[idx][8*b +: 8] = c_wd[8*b +: 8];
      end else c_data = ref_mem[idx];
      ph = 2;
    end else if (m_grant >= 0) begin
      c_addr = a[m_grant]; c_wd = wd[m_grant]; c_bm = bm[m_grant]; c_we = we[m_grant];
      c_id = m_grant;
      cnt = (m_grant == 1 || !v[1]) ? 0 : cnt + 1;
      v[m_grant] = 0;
      ph = 1;
    end else ph = 0;
  endtask
  task automatic cycle();
    @(negedge clk);
    compare();
    if (d_grant >= 0) begin gport.push_back(d_grant); gcyc.push_back(cyc); end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst) step();
  endtask
  int exp_seq[10];
  initial begin
    cyc = 0;
    model_reset();
    repeat (2) cycle();
    chk("reset_busy", busy, 0);
    chk("reset_mem_en", men, 0);
    rst = 0;
    set_req(1, 32'h100, 32'hDEADBEEF, 4'hF, 1);
    cycle();
    chk("st_full_en", men, 1);
    chk("st_full_wren", mwe, 1);
    cycle();
    chk("st_full_rsp1", rv1, 1);
    cycle();
    set_req(1, 32'h40, 32'h12345678, 4'b0011, 1);
    cycle();
    chk("st_en", men, 1);
    chk("st_wren", mwe, 1);
    chk("st_bmask", mbm, 4'b0011);
    chk("st_addr", maddr, 32'h40);
    cycle();
    chk("st_rsp1", rv1, 1);
    chk("st_rdata1", rd1, 0);
    chk("st_rsp0", rv0, 0);
    cycle();
    set_req(0, 32'h100, 32'h0, 4'hF, 0);
    cycle();
    chk("ld_en", men, 1);
    chk("ld_wren", mwe, 0);
    chk("ld_addr", maddr, 32'h100);
    cycle();
    chk("ld_rsp0", rv0, 1);
    chk("ld_rdata0", rd0, 32'hDEADBEEF);
    chk("ld_rsp1", rv1, 0);
    cycle();
    set_req(0, 32'h8, 32'hAAAA5555, 4'hF, 1);
    cycle();
    chk("rst_pre_en", men, 1);
    rst = 1;
    model_reset();
    #1;
    chk("rst_en", men, 0);
    chk("rst_wren", mwe, 0);
    chk("rst_addr", maddr, 0);
    chk("rst_wdata", mwd, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp0", rv0, 0);
    repeat (2) cycle();
    rst = 0;
    set_req(0, 32'h8, 32'h0, 4'hF, 0);
    cycle();
    chk("post_rst_en", men, 1);
    cycle();
    chk("post_rst_rsp0", rv0, 1);
    chk("post_rst_rdata", rd0, 0);
    cycle();
    rst = 1;
    model_reset();
    cycle();
    rst = 0;
    gport.delete();
    gcyc.delete();
    for (int i = 0; i < 60 && gport.size() < 10; i++) begin
      for (int p = 0; p < 2; p++)
        if (!v[p]) set_req(p, $urandom, $urandom, 4'($urandom), 1'($urandom));
      cycle();
    end
    if (FAIR) exp_seq = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    else exp_seq = '{default: 0};
    chk("fair_grant_count", gport.size() >= 10, 1);
    for (int i = 0; i < 10 && i < gport.size(); i++) begin
      chk("fair_grant_port", gport[i], exp_seq[i]);
      if (i > 0) chk("fair_grant_spacing", gcyc[i] - gcyc[i-1], 2);
    end
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++)
        if (!v[p] && $urandom_range(0, 2) == 0) set_req(p, $urandom, $urandom, 4'($urandom), 1'($urandom));
      cycle();
    end
    v[0] = 0;
    v[1] = 0;
    repeat (4) cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter and sequencer for the shared data memory behind the LSU. Port 0 is the CPU load/store path and port 1 is a secondary master such as a debug loader or DMA. The block accepts one request at a time over valid/ready, drives a single-port synchronous memory with 1-cycle read latency, and returns a response pulse to the granted port. It sits between the requesters and the memory macro; it never reorders traffic or holds more than one transaction in flight.

## Interface
- ADDR_W, 32, request/memory address width
- DATA_W, 32, data width; byte-mask width is DATA_W/8
- MAX_HOLD, 4, consecutive port-0 grants allowed while port 1 waits (fairness feature only)

- i_clk  in  1  clock
- i_reset  in  1  reset; asynchronous, active-high
- i_req{0,1}_valid  in  1  request valid
- o_req{0,1}_ready  out  1  request accepted when valid&&ready
- i_req{0,1}_addr  in  ADDR_W  address, forwarded unmodified
- i_req{0,1}_wdata  in  DATA_W  store data
- i_req{0,1}_bmask  in  DATA_W/8  byte enables
- i_req{0,1}_wren  in  1  1=store, 0=load
- o_rsp{0,1}_valid  out  1  one-cycle response pulse
- o_rsp{0,1}_rdata  out  DATA_W  load data; 0 for stores
- o_mem_en  out  1  memory access strobe
- o_mem_wren  out  1  memory write enable
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  memory write data
- o_mem_bmask  out  DATA_W/8  memory byte enables
- i_mem_rdata  in  DATA_W  read data, valid the cycle after o_mem_en with o_mem_wren=0
- o_busy  out  1  high in ACCESS or RESP

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE→ACCESS on any handshake. ACCESS→RESP unconditionally. RESP→ACCESS if a handshake occurs in RESP, else RESP→IDLE.
- Readiness: ready is asserted only in IDLE and RESP, and only to the port picked by arbitration. At most one ready is high per cycle.
- Arbitration (default): fixed priority, port 0 over port 1.
- On handshake:
  - Latch addr, wdata, bmask, wren and the port id into the command register.
  - Requester fields need not be held after acceptance.
- ACCESS:
  - o_mem_en=1.
  - Memory outputs are driven from the command register.
- RESP:
  - o_rsp{id}_valid=1.
  - rdata is i_mem_rdata for loads and 0 for stores.
  - The other port's rsp_valid stays 0.
- Requester rule: once valid is asserted it stays high, with fields stable, until the handshake.
- Memory outputs:
  - o_mem_wren, addr, wdata and bmask hold the command register continuously.
  - Only o_mem_en qualifies them.
- Reset (asynchronous, any state):
  - State goes to IDLE; command register and counter clear; all outputs go to 0.
  - An in-flight transaction is dropped with no response.
  - If reset asserts before the ACCESS edge completes, the store is not performed.

## Timing
- Handshake at edge T → o_mem_en high during cycle T+1 → o_rsp_valid high during cycle T+2.
- Latency: 2 cycles from acceptance to response.
- Throughput: back-to-back accepts in RESP give one transaction per 2 cycles.
- Ready is combinational from state, the valids and the counter. It has no combinational path from data inputs.
- Simultaneous valid on both ports in IDLE/RESP: exactly one is granted; the loser sees ready=0 and waits.

## Configuration
- Macro: MEM_ARB_FAIR_EN.
- Defined:
  - A hold counter of width $clog2(MAX_HOLD+1) increments on each port-0 grant while i_req1_valid=1.
  - The counter clears on a port-1 grant, or on a port-0 grant with i_req1_valid=0.
  - When the counter equals MAX_HOLD and both ports are valid, port 1 is granted.
  - The counter never exceeds MAX_HOLD.
- Undefined:
  - Pure fixed priority; no counter logic is compiled.
  - Port 1 can starve indefinitely.

## Structure
- Package mem_arb_pkg holds:
  - the state enum: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2
  - the port id constants PORT_CPU=1'b0, PORT_AUX=1'b1
  - the command struct: addr, wdata, bmask, wren, id
- One sub-module, mem_arb_pick: grant decision plus the hold counter, with the counter under MEM_ARB_FAIR_EN. The top level holds the FSM, command register and response mux.

## Test plan
- Single load, port 0, addr 0x100, memory returns 0xDEADBEEF → o_mem_en high at T+1 with wren=0, addr 0x100; o_rsp0_valid at T+2 with rdata 0xDEADBEEF; o_rsp1_valid stays 0.
- Port 1 store, addr 0x40, wdata 0x12345678, bmask 4'b0011 → o_mem_en=1, wren=1, bmask 0011 at T+1; o_rsp1_valid at T+2 with rdata 0.
- Both ports valid continuously, MEM_ARB_FAIR_EN defined, MAX_HOLD=4 → grant sequence 0,0,0,0,1,0,0,0,0,1; back-to-back grants every 2 cycles.
- Same stimulus, macro undefined → port 0 granted every time; o_req1_ready never asserts.
- Reset asserted mid-ACCESS of a port-0 store → all outputs 0 immediately; no rsp0_valid; FSM in IDLE; the next request completes normally with 2-cycle latency.
